// File: rtl/expr_feeder.sv
// expr_feeder: valid/ready front end for the fixed-latency expr core, buffering results under credit flow control.
// Defining EXPR_FEEDER_TAG_EN adds out_x, the operand that produced each buffered result.
module expr_feeder #(
   parameter int LATENCY = 16,
   parameter int DEPTH   = 4,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_x,
   output logic [DW-1:0] ex_x,
   input  logic [DW-1:0] ex_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_result,
`ifdef EXPR_FEEDER_TAG_EN
   output logic [DW-1:0] out_x,
`endif
   output logic          busy
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic               r_active;
   logic [DW-1:0]      r_exX;
   logic [LATENCY-1:0] r_vpipe;
   logic [CW-1:0]      r_credit;
   logic [CW-1:0]      r_count;
   logic [PW-1:0]      r_wrPtr;
   logic [PW-1:0]      r_rdPtr;
   logic [DW-1:0]      r_resMem [DEPTH];

   logic w_accept;
   logic w_pop;
   logic w_push;

   assign w_accept   = in_valid & in_ready;
   assign w_pop      = out_valid & out_ready;
   assign w_push     = r_vpipe[LATENCY-1];
   // in_ready depends only on registered state, so out_ready never reaches it combinationally
   assign in_ready   = r_active & (r_credit < FULL);
   assign out_valid  = (r_count != '0);
   assign out_result = r_resMem[r_rdPtr];
   assign busy       = (r_credit != '0);
   assign ex_x       = r_exX;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_active <= 1'b0;
         r_exX    <= '0;
         r_vpipe  <= '0;
      end else begin
         r_active   <= 1'b1;
         r_vpipe[0] <= w_accept;
         for (int i = 1; i < LATENCY; i++) begin
            r_vpipe[i] <= r_vpipe[i-1];
         end
         if (w_accept) begin
            r_exX <= in_x;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_credit <= '0;
      end else if (w_accept && !w_pop) begin
         r_credit <= r_credit + CW'(1);
      end else if (w_pop && !w_accept) begin
         r_credit <= r_credit - CW'(1);
      end
   end

   // Credits guarantee a free slot whenever a valid slot reaches the end of the pipe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_resMem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_resMem[r_wrPtr] <= ex_result;
            r_wrPtr           <= (r_wrPtr == LAST) ? '0 : r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= (r_rdPtr == LAST) ? '0 : r_rdPtr + PW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

`ifdef EXPR_FEEDER_TAG_EN
   logic [DW-1:0] r_xPipe  [LATENCY];
   logic [DW-1:0] r_tagMem [DEPTH];

   assign out_x = r_tagMem[r_rdPtr];

   // Slot 0 holds the operand as the core sees it, keeping it aligned with r_vpipe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_xPipe[i] <= '0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            r_tagMem[i] <= '0;
         end
      end else begin
         r_xPipe[0] <= w_accept ? in_x : r_exX;
         for (int i = 1; i < LATENCY; i++) begin
            r_xPipe[i] <= r_xPipe[i-1];
         end
         if (w_push) begin
            r_tagMem[r_wrPtr] <= r_xPipe[LATENCY-1];
         end
      end
   end
`endif

endmodule

// File: tb/tb_expr_feeder.sv
// tb_expr_feeder: directed bench for expr_feeder (LATENCY=4, DEPTH=4, plus a DEPTH=8 instance for streaming).
// A stand-in core returns x+1; a small credit/occupancy model checks handshakes every cycle.
module tb_expr_feeder;

   localparam int LAT = 4;
   localparam int DW  = 32;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int errors   = 0;
   int cycleCnt = 0;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   logic          inValid  = 1'b0;
   logic          outReady = 1'b0;
   logic [DW-1:0] inX      = '0;
   logic          inReady, outValid, busy;
   logic [DW-1:0] exX, exResult, outResult;
`ifdef EXPR_FEEDER_TAG_EN
   logic [DW-1:0] outX;
`endif

   logic          in8Valid  = 1'b0;
   logic          out8Ready = 1'b1;
   logic [DW-1:0] in8X      = '0;
   logic          in8Ready, out8Valid, busy8;
   logic [DW-1:0] ex8X, ex8Result, out8Result;
`ifdef EXPR_FEEDER_TAG_EN
   logic [DW-1:0] out8X;
`endif

   // Stand-in core: x+1 through LAT-1 register stages, so a capture LAT edges after acceptance sees it
   logic [DW-1:0] corePipe  [LAT-1];
   logic [DW-1:0] core8Pipe [LAT-1];
   always @(posedge clk) begin
      corePipe[0]  <= exX + 32'd1;
      core8Pipe[0] <= ex8X + 32'd1;
      for (int k = 1; k < LAT - 1; k++) begin
         corePipe[k]  <= corePipe[k-1];
         core8Pipe[k] <= core8Pipe[k-1];
      end
   end
   assign exResult  = corePipe[LAT-2];
   assign ex8Result = core8Pipe[LAT-2];

   expr_feeder #(.LATENCY(LAT), .DEPTH(4), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(inValid), .in_ready(inReady), .in_x(inX),
      .ex_x(exX), .ex_result(exResult),
      .out_valid(outValid), .out_ready(outReady), .out_result(outResult),
`ifdef EXPR_FEEDER_TAG_EN
      .out_x(outX),
`endif
      .busy(busy)
   );

   expr_feeder #(.LATENCY(LAT), .DEPTH(8), .DW(DW)) dut8 (
      .clk(clk), .reset(reset),
      .in_valid(in8Valid), .in_ready(in8Ready), .in_x(in8X),
      .ex_x(ex8X), .ex_result(ex8Result),
      .out_valid(out8Valid), .out_ready(out8Ready), .out_result(out8Result),
`ifdef EXPR_FEEDER_TAG_EN
      .out_x(out8X),
`endif
      .busy(busy8)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at cycle %0d", tag, observed, expected, cycleCnt);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one operand and returns just after the edge that accepted it
   task automatic applyStimulus(input logic [DW-1:0] x);
      int  waited = 0;
      bit  wasReady;
      inValid = 1'b1;
      inX     = x;
      do begin
         wasReady = inReady;
         tick();
         waited++;
      end while (!wasReady && waited < 50);
      if (!wasReady) checkOutput("sendTimeout", 32'd0, 32'd1);
      inValid = 1'b0;
   endtask

   // Reference model for the DEPTH=4 instance, evaluated between edges
   logic [LAT-1:0] modelPipe   = '0;
   int             modelCredit = 0;
   int             modelCount  = 0;
   bit             modelActive = 1'b0;
   int             acceptCnt   = 0;
   logic [DW-1:0]  expQ[$];
   logic [DW-1:0]  popLog[$];

   always @(negedge clk) begin
      bit            expReady, expValid, acc, pop, push;
      logic [DW-1:0] want;
      if (reset !== 1'b1) begin
         modelPipe   = '0;
         modelCredit = 0;
         modelCount  = 0;
         modelActive = 1'b0;
         expQ.delete();
      end else begin
         expReady = modelActive && (modelCredit < 4);
         expValid = (modelCount != 0);
         checkOutput("inReady", inReady, expReady);
         checkOutput("outValid", outValid, expValid);
         checkOutput("busy", busy, modelCredit != 0);
         if (dut.r_vpipe[LAT-1]) checkOutput("captureRoom", dut.r_count != 3'd4, 1'b1);
         acc  = inValid && expReady;
         pop  = expValid && outReady;
         push = modelPipe[LAT-1];
         if (inValid && inReady) acceptCnt++;
         if (pop) begin
            want = (expQ.size() != 0) ? expQ.pop_front() : 32'hdeadbeef;
            checkOutput("popOrder", outResult, want);
            popLog.push_back(outResult);
`ifdef EXPR_FEEDER_TAG_EN
            checkOutput("tagPair", outX, want - 32'd1);
`endif
         end
         if (acc) expQ.push_back(inX + 32'd1);
         modelPipe   = {modelPipe[LAT-2:0], acc};
         modelCount  = modelCount + int'(push) - int'(pop);
         modelCredit = modelCredit + int'(acc) - int'(pop);
         modelActive = 1'b1;
      end
   end

   logic [DW-1:0] b2bVals[$];
   int            b2bCyc[$];
   always @(negedge clk) begin
      if (reset === 1'b1 && out8Valid && out8Ready) begin
         b2bVals.push_back(out8Result);
         b2bCyc.push_back(cycleCnt);
      end
   end

   task automatic checkLog(input string tag, input logic [DW-1:0] firstVal, input int n);
      checkOutput({tag, "Count"}, popLog.size(), n);
      for (int i = 0; i < n && i < popLog.size(); i++) begin
         checkOutput(tag, popLog[i], firstVal + i);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cycleCnt);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstExX", exX, 32'd0);
      checkOutput("rstInReady", inReady, 1'b0);
      checkOutput("rstOutValid", outValid, 1'b0);
      checkOutput("rstOutResult", outResult, 32'd0);
      checkOutput("rstBusy", busy, 1'b0);
`ifdef EXPR_FEEDER_TAG_EN
      checkOutput("rstOutX", outX, 32'd0);
`endif
      reset = 1'b1;
      checkOutput("readyHeldLow", inReady, 1'b0);
      tick();
      checkOutput("readyAfterRst", inReady, 1'b1);

      $display("[TB] single operand");
      outReady = 1'b1;
      applyStimulus(32'h3f000000);
      checkOutput("singleExX", exX, 32'h3f000000);
      repeat (3) tick();
      checkOutput("singleNotYet", outValid, 1'b0);
      tick();
      checkOutput("singleValid", outValid, 1'b1);
      checkOutput("singleResult", outResult, 32'h3f000001);
      checkOutput("singleBusy", busy, 1'b1);
      tick();
      checkOutput("singleEmpty", outValid, 1'b0);
      checkOutput("singleIdle", busy, 1'b0);

      $display("[TB] back-to-back on DEPTH=8");
      in8Valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in8X = 32'(i + 1);
         checkOutput("b2bReady", in8Ready, 1'b1);
         tick();
      end
      in8Valid = 1'b0;
      repeat (10) tick();
      checkOutput("b2bCount", b2bVals.size(), 8);
      for (int i = 0; i < 8 && i < b2bVals.size(); i++) begin
         checkOutput("b2bValue", b2bVals[i], 32'(i + 2));
         if (i > 0) checkOutput("b2bGap", b2bCyc[i] - b2bCyc[i-1], 1);
      end

      $display("[TB] backpressure");
      outReady  = 1'b0;
      acceptCnt = 0;
      popLog.delete();
      for (int x = 10; x < 14; x++) applyStimulus(32'(x));
      inValid = 1'b1;
      inX     = 32'd14;
      repeat (6) begin
         tick();
         checkOutput("bpStall", inReady, 1'b0);
      end
      checkOutput("bpAccepted", acceptCnt, 4);
      checkOutput("bpHeadValid", outValid, 1'b1);
      checkOutput("bpHeadHeld", outResult, 32'd11);
      outReady = 1'b1;
      applyStimulus(32'd14);
      applyStimulus(32'd15);
      repeat (12) tick();
      checkLog("bpLog", 32'd11, 6);

      $display("[TB] push and pop together near full");
      outReady = 1'b0;
      popLog.delete();
      for (int x = 20; x < 24; x++) applyStimulus(32'(x));
      repeat (3) tick();
      checkOutput("fullNoRoom", inReady, 1'b0);
      outReady = 1'b1;
      inValid  = 1'b1;
      inX      = 32'd24;
      tick();
      checkOutput("pushPopReady", inReady, 1'b1);
      checkOutput("pushPopHead", outResult, 32'd22);
      tick();
      checkOutput("accPopReady", inReady, 1'b1);
      checkOutput("accPopExX", exX, 32'd24);
      checkOutput("accPopHead", outResult, 32'd23);
      inValid = 1'b0;
      for (int x = 25; x < 28; x++) applyStimulus(32'(x));
      repeat (12) tick();
      checkLog("ppLog", 32'd21, 8);

      $display("[TB] reset with work in flight");
      popLog.delete();
      applyStimulus(32'd40);
      applyStimulus(32'd41);
      applyStimulus(32'd42);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midRstExX", exX, 32'd0);
      checkOutput("midRstInReady", inReady, 1'b0);
      checkOutput("midRstOutValid", outValid, 1'b0);
      checkOutput("midRstOutResult", outResult, 32'd0);
      checkOutput("midRstBusy", busy, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      tick();
      checkOutput("midRstReady", inReady, 1'b1);
      repeat (8) tick();
      checkOutput("noStale", popLog.size(), 0);
      applyStimulus(32'h40000000);
      repeat (3) tick();
      checkOutput("newNotYet", outValid, 1'b0);
      tick();
      checkOutput("newValid", outValid, 1'b1);
      checkOutput("newResult", outResult, 32'h40000001);
      repeat (4) tick();
      checkLog("newLog", 32'h40000001, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
